// File: rtl/bus_trace_buffer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : bus_trace_buffer_pkg                                      |
// | Purpose : Shared types and field layout for the 6502 bus trace      |
// |           buffer (entry = {sync, rw, addr[15:0], data[7:0]}).       |
// | Rev     : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package bus_trace_buffer_pkg;

   // Width of one trace entry and the bit offset of each field
   localparam int TRACE_W = 26;
   localparam int TR_DATA = 0;
   localparam int TR_ADDR = 8;
   localparam int TR_RW   = 24;
   localparam int TR_SYNC = 25;

   // Packed layout matches the offsets above (MSB first)
   typedef struct packed {
      logic        sync;
      logic        rw;
      logic [15:0] addr;
      logic [7:0]  data;
   } trace_entry_t;

endpackage : bus_trace_buffer_pkg
`default_nettype wire

// File: rtl/bus_trace_buffer_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : bus_trace_buffer_ram                                      |
// | Purpose : 2**AW x W trace store, one write port and one registered  |
// |           read port; maps to distributed RAM plus an output reg.    |
// | Rev     : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module bus_trace_buffer_ram #(
   parameter int AW = 4,
   parameter int W  = 26
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [0:(2**AW)-1];

   // Write port: storage itself is never reset, only made unreachable
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Registered read port; reset so the read outputs come up as zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata <= '0;
      else        rdata <= mem[raddr];
   end

endmodule : bus_trace_buffer_ram
`default_nettype wire

// File: rtl/bus_trace_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : bus_trace_buffer                                          |
// | Purpose : Records the last 2**AW 6502 bus cycles while the CPU      |
// |           runs; when frozen, steps through them oldest first.       |
// | Rev     : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module bus_trace_buffer
   import bus_trace_buffer_pkg::*;
#(
   parameter int AW = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        phi2,
   input  logic        rw,
   input  logic        sync,
   input  logic [15:0] addr,
   input  logic [7:0]  data,
   input  logic        enable,
   input  logic        clear,
   input  logic        rd_rewind,
   input  logic        rd_step,
   output logic [15:0] rd_addr,
   output logic [7:0]  rd_data,
   output logic        rd_rw,
   output logic        rd_sync,
   output logic        rd_valid,
   output logic [AW:0] count,
   output logic        wrapped
);

   localparam int          DEPTH = 2**AW;
   localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);

   logic          phi2_q;
   trace_entry_t  bus_q;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_idx;
   logic          fall;
   logic          we;
   logic [AW:0]   count_nxt;
   logic [AW-1:0] rd_idx_nxt;
   logic [AW-1:0] raddr;
   trace_entry_t  rd_entry;

   // Sample the synchronised bus every clock; bus_q holds the phi2-high
   // sample at the moment the falling edge is detected
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phi2_q <= 1'b0;
         bus_q  <= '0;
      end else begin
         phi2_q <= phi2;
         bus_q  <= '{sync: sync, rw: rw, addr: addr, data: data};
      end
   end

   assign fall = phi2_q & ~phi2;
   // clear outranks capture, and a frozen buffer never records
   assign we   = fall & enable & ~clear;

   // Next-state for count and read index
   always_comb begin
      count_nxt  = count;
      rd_idx_nxt = rd_idx;
      if (clear) begin
         count_nxt = '0;
      end else if (we && count != FULL) begin
         count_nxt = count + 1'b1;
      end
      if (clear || enable || rd_rewind) begin
         rd_idx_nxt = '0;
      end else if (rd_step && (({1'b0, rd_idx} + 1'b1) < count)) begin
         rd_idx_nxt = rd_idx + 1'b1;
      end
   end

   // Pointer, count, wrap flag and read index state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         count    <= '0;
         wrapped  <= 1'b0;
         rd_idx   <= '0;
         rd_valid <= 1'b0;
      end else begin
         count    <= count_nxt;
         rd_idx   <= rd_idx_nxt;
         rd_valid <= ~enable & (count_nxt != '0);
         if (clear) begin
            wrapped <= 1'b0;
         end else if (we) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (count == FULL) wrapped <= 1'b1;
         end
      end
   end

   // Oldest entry sits count slots behind the write pointer; when full the
   // low AW bits of count are zero so oldest == wr_ptr
   assign raddr = wr_ptr - count[AW-1:0] + rd_idx;

   bus_trace_buffer_ram #(
      .AW (AW),
      .W  (TRACE_W)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .waddr (wr_ptr),
      .wdata (bus_q),
      .raddr (raddr),
      .rdata (rd_entry)
   );

   assign rd_addr = rd_entry.addr;
   assign rd_data = rd_entry.data;
   assign rd_rw   = rd_entry.rw;
   assign rd_sync = rd_entry.sync;

endmodule : bus_trace_buffer
`default_nettype wire

// File: tb/tb_bus_trace_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_bus_trace_buffer                                       |
// | Purpose : Scoreboard bench for bus_trace_buffer with a queue-based  |
// |           history model and randomized bus traffic.                 |
// | Rev     : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tb_bus_trace_buffer;

   localparam int AW    = 4;
   localparam int DEPTH = 2**AW;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        phi2, rw, sync, enable, clear, rd_rewind, rd_step;
   logic [15:0] addr;
   logic [7:0]  data;
   logic [15:0] rd_addr;
   logic [7:0]  rd_data;
   logic        rd_rw, rd_sync, rd_valid, wrapped;
   logic [AW:0] count;

   int tests = 0;
   int fails = 0;

   // Reference model: history oldest-first, wrap flag, viewing index
   logic [25:0] hist[$];
   logic [25:0] exp_q[$];
   bit          m_wrapped;
   int          m_idx;

   bus_trace_buffer #(.AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .phi2(phi2), .rw(rw), .sync(sync),
      .addr(addr), .data(data), .enable(enable), .clear(clear),
      .rd_rewind(rd_rewind), .rd_step(rd_step), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_rw(rd_rw), .rd_sync(rd_sync),
      .rd_valid(rd_valid), .count(count), .wrapped(wrapped)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare presented entry against the next expected one
   initial begin
      logic [25:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd_entry", {5'd0, rd_valid, rd_sync, rd_rw, rd_addr, rd_data},
                  {5'd0, 1'b1, e});
         end
      end
   end

   task automatic model_clear();
      hist.delete();
      m_wrapped = 1'b0;
      m_idx     = 0;
   endtask

   task automatic model_capture(input logic [25:0] e);
      if (hist.size() == DEPTH) begin
         void'(hist.pop_front());
         m_wrapped = 1'b1;
      end
      hist.push_back(e);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() > 0) begin
         check("scoreboard_timeout", 32'(exp_q.size()), 0);
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   // Called two clocks after a readback action: outputs now reflect it
   task automatic expect_out();
      if (hist.size() > 0) begin
         exp_q.push_back(hist[m_idx]);
         drain();
      end else begin
         @(negedge clk);
         check("rd_valid_empty", 32'(rd_valid), 0);
      end
   endtask

   task automatic check_status(input string tag);
      @(negedge clk);
      check({tag, "_count"}, 32'(count), 32'(hist.size()));
      check({tag, "_wrapped"}, 32'(wrapped), 32'(m_wrapped));
   endtask

   // One full PHI2 period: two clocks high, two low; optional clear at the fall
   task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d,
                            input logic r, input logic s, input bit clr);
      @(posedge clk); #1;
      phi2 = 1'b1; addr = a; data = d; rw = r; sync = s;
      @(posedge clk); #1;
      @(posedge clk); #1;
      phi2 = 1'b0; addr = 16'($urandom); data = 8'($urandom);
      rw = 1'($urandom); sync = 1'($urandom); clear = clr;
      @(posedge clk); #1;
      clear = 1'b0;
      if (clr)         model_clear();
      else if (enable) model_capture({s, r, a, d});
      @(posedge clk); #1;
   endtask

   task automatic freeze();
      @(posedge clk); #1;
      enable = 1'b0;
      m_idx  = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      expect_out();
   endtask

   task automatic rd_op(input bit stp, input bit rew, input bit clr);
      @(posedge clk); #1;
      rd_step = stp; rd_rewind = rew; clear = clr;
      @(posedge clk); #1;
      rd_step = 1'b0; rd_rewind = 1'b0; clear = 1'b0;
      if (clr)                            model_clear();
      else if (rew)                       m_idx = 0;
      else if (stp && m_idx < hist.size() - 1) m_idx++;
      @(posedge clk); #1;
      expect_out();
   endtask

   initial begin
      int n;
      rst_n = 1'b0; phi2 = 0; rw = 0; sync = 0; addr = 0; data = 0;
      enable = 0; clear = 0; rd_rewind = 0; rd_step = 0;
      model_clear();
      #2;
      check("reset_count", 32'(count), 0);
      check("reset_wrapped", 32'(wrapped), 0);
      check("reset_outputs", {6'd0, rd_valid, rd_sync, rd_rw, rd_addr, rd_data}, 0);
      #10 rst_n = 1'b1;

      // Three-cycle capture, then browse
      enable = 1'b1;
      bus_cycle(16'h0200, 8'hA9, 1'b1, 1'b1, 1'b0);
      bus_cycle(16'h0201, 8'h05, 1'b1, 1'b0, 1'b0);
      bus_cycle(16'h0202, 8'h00, 1'b1, 1'b0, 1'b0);
      check_status("three");
      freeze();
      rd_op(1, 0, 0);
      rd_op(1, 0, 0);
      rd_op(1, 0, 0);

      // Overfill: 20 writes into 16 slots
      rd_op(0, 0, 1);
      enable = 1'b1;
      for (int i = 0; i < 20; i++)
         bus_cycle(16'(i), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      check_status("wrap");
      freeze();
      for (int i = 0; i < 15; i++) rd_op(1, 0, 0);
      rd_op(1, 0, 0);

      // Frozen: PHI2 activity must not record; rewind beats step
      for (int i = 0; i < 5; i++)
         bus_cycle(16'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
      check_status("frozen");
      rd_op(0, 1, 1'b0);
      rd_op(1, 1, 1'b0);

      // Clear coincident with a falling edge, then one more capture
      enable = 1'b1;
      bus_cycle(16'h1234, 8'h56, 1'b0, 1'b1, 1'b1);
      check_status("clear_edge");
      freeze();
      enable = 1'b1;
      bus_cycle(16'h4321, 8'h65, 1'b1, 1'b0, 1'b0);
      check_status("after_clear");

      // Randomized capture/browse rounds
      for (int r = 0; r < 6; r++) begin
         enable = 1'b1;
         n = $urandom_range(1, 24);
         for (int i = 0; i < n; i++)
            bus_cycle(16'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 19) == 0);
         check_status("rand");
         freeze();
         for (int k = 0; k < 10; k++) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3, 4: rd_op(1, 0, 0);
               5, 6:          rd_op(0, 1, 0);
               7, 8:          rd_op(1, 1, 0);
               default:       rd_op(0, 0, ($urandom_range(0, 3) == 0));
            endcase
         end
      end

      // Asynchronous reset in the middle of a capture
      enable = 1'b1;
      bus_cycle(16'hBEEF, 8'hCA, 1'b1, 1'b1, 1'b0);
      @(posedge clk); #1;
      phi2 = 1'b1; addr = 16'hFACE; data = 8'h77;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("async_count", 32'(count), 0);
      check("async_wrapped", 32'(wrapped), 0);
      check("async_outputs", {6'd0, rd_valid, rd_sync, rd_rw, rd_addr, rd_data}, 0);
      model_clear();
      phi2 = 1'b0;
      #7 rst_n = 1'b1;
      check_status("post_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_bus_trace_buffer
`default_nettype wire
